pipeline_ctrl: RTL
==================

# pipeline_ctrl

Pipeline control unit that drives the `EN` and `flush` inputs of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable. It resolves four conditions each cycle: data-memory wait, control redirect, load-use hazard and instruction-fetch miss. It also latches halt and counts stall cycles. It sits beside the datapath and consumes only pipeline-register outputs and cache hit signals.

## Interface
Parameters:
- `CNT_W`, default 32: width of the stall-cycle counter.

Ports:
- `CLK` in 1: clock. One clock domain.
- `RST` in 1: reset, synchronous, active-high.
- `ihit` in 1: instruction fetch completes this cycle.
- `dhit` in 1: data access completes this cycle.
- `ifid_instr` in 32: IF/ID `instr_o`; rs is [25:21], rt is [20:16].
- `idex_dREN` in 1, `idex_wsel` in 5: ID/EX `dREN_o` and `wsel_o`.
- `exmem_dREN` in 1, `exmem_dWEN` in 1: EX/MEM memory request.
- `ex_redirect` in 1: branch taken or jump resolved in EX.
- `memwb_halt` in 1: MEM/WB `halt_o`.
- `pc_EN` out 1: PC write enable.
- `ifid_EN`, `ifid_flush`, `idex_EN`, `idex_flush`, `exmem_EN`, `exmem_flush`, `memwb_EN`, `memwb_flush` out 1 each: pipeline-register controls.
- `halted` out 1: core halted (sticky).
- `stall_cnt` out CNT_W: count of cycles with `pc_EN`=0 while not halted.

## Operation
The FSM state is registered. Control outputs are combinational from the state and the current inputs.

States:
- **RUN**
  - A memory request with no hit (`(exmem_dREN|exmem_dWEN) & !dhit`) applies the D-stall pattern and moves to DWAIT.
  - Otherwise apply the highest-priority rule from the priority list below.
  - `memwb_halt`=1 moves to HALT. It takes precedence over all other transitions.
- **DWAIT**
  - Apply the D-stall pattern until `dhit`=1.
  - On `dhit`, drive the RUN rules for that same cycle and return to RUN.
- **HALT**
  - All `EN`=0 and all `flush`=0. `halted`=1.
  - Exited only by `RST`.

Priority in RUN (the highest applicable rule wins). Any signal not listed is `EN`=1, `flush`=0:
1. D-stall:
   - `pc_EN`, `ifid_EN`, `idex_EN`, `exmem_EN` = 0.
   - `memwb_EN`=1 and `memwb_flush`=1, so a bubble enters WB and no writeback repeats.
2. Redirect (`ex_redirect`):
   - `pc_EN`=1, regardless of `ihit`.
   - `ifid_flush`=1 and `idex_flush`=1, with `EN`=1 on both.
3. Load-use (`idex_dREN` & `idex_wsel`≠0 & `idex_wsel`∈{rs,rt}):
   - `pc_EN`=0 and `ifid_EN`=0.
   - `idex_EN`=1 and `idex_flush`=1.
4. Fetch miss (`!ihit`):
   - `pc_EN`=0.
   - `ifid_EN`=1 and `ifid_flush`=1.
5. Otherwise all `EN`=1 and all `flush`=0.

Counter:
- `stall_cnt` increments when `pc_EN`=0 and state≠HALT.
- It saturates at all-ones; it does not wrap.

## Timing
- Reset: while `RST`=1, all `EN`=0 and all `flush`=1. State becomes RUN, `halted`=0 and `stall_cnt`=0 at the next edge.
- Reset asserted mid-DWAIT or mid-HALT returns to RUN on the next edge. Any outstanding memory request is dropped.
- Detection to control outputs is combinational, with zero latency. The state update takes 1 cycle.
- A load-use stall lasts exactly 1 cycle, because the bubble removes the hazard.
- `dhit` in the same cycle as a request means no DWAIT entry and no D-stall.
- Redirect together with a pending D-stall: the D-stall wins. The redirect is re-evaluated once `dhit` arrives, because EX is held.
- Redirect together with load-use: the redirect wins, since the dependent instruction is flushed.
- `memwb_halt` together with D-stall: HALT is entered and `halted`=1 on the next cycle.

## Structure
- Add `pctrl_state_t` enum {RUN, DWAIT, HALT} to `cpu_types_pkg`.
- Sub-module `load_use_detect`: combinational. Takes `ifid_instr`, `idex_dREN` and `idex_wsel`, and outputs `lu_hazard`.
- The top holds the FSM, the output-priority mux and the counter.

## Test plan
- **Reset:** `RST`=1 for 2 cycles. Expect all `EN`=0, all `flush`=1. After release, `halted`=0 and `stall_cnt`=0.
- **Load-use:** `idex_dREN`=1, `idex_wsel`=5, `ifid_instr` rs=5, `ihit`=1. Expect 1 cycle of `pc_EN`=0, `ifid_EN`=0, `idex_flush`=1, and `stall_cnt`=1. Repeat with `idex_wsel`=0: expect no stall.
- **Data wait:** `exmem_dREN`=1 with `dhit` low for 3 cycles. Expect `exmem_EN`=0 and `memwb_flush`=1 for 3 cycles. On the `dhit` cycle, all `EN`=1. `stall_cnt`=3.
- **Redirect precedence:** `ex_redirect`=1, `ihit`=0, load-use true. Expect `pc_EN`=1, `ifid_flush`=1, `idex_flush`=1.
- **Halt:** `memwb_halt`=1 during a D-stall. Expect `halted`=1 next cycle and all outputs 0 thereafter while the inputs toggle. `RST` returns the unit to RUN.
- **Saturation:** with `CNT_W`=4, hold `ihit`=0 for 20 cycles. Expect `stall_cnt`=15.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline control unit: FSM states and the bundled
// per-stage enable/flush control vector with its fixed patterns.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } pctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_en;
    logic memwb_flush;
  } pctrl_ctrl_t;

  localparam pctrl_ctrl_t CTRL_GO     = 9'b1_10_10_10_10;
  localparam pctrl_ctrl_t CTRL_FETCH  = 9'b0_11_10_10_10;
  localparam pctrl_ctrl_t CTRL_LU     = 9'b0_00_11_10_10;
  localparam pctrl_ctrl_t CTRL_REDIR  = 9'b1_11_11_10_10;
  // Only MEM/WB advances, taking a bubble so the last writeback is not repeated.
  localparam pctrl_ctrl_t CTRL_DSTALL = 9'b0_00_00_00_11;
  localparam pctrl_ctrl_t CTRL_RESET  = 9'b0_01_01_01_01;
  localparam pctrl_ctrl_t CTRL_FROZEN = 9'b0_00_00_00_00;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check: the load in ID/EX writes a register
// that the instruction in IF/ID reads (rs or rt); $zero never conflicts.
module load_use_detect
  import cpu_types_pkg::*;
(
  input  logic [31:0] ifid_instr,
  input  logic        idex_dREN,
  input  logic [4:0]  idex_wsel,
  output logic        lu_hazard
);

  logic [4:0] rs;
  logic [4:0] rt;
  logic       unused_instr_bits;

  assign rs = ifid_instr[25:21];
  assign rt = ifid_instr[20:16];
  assign unused_instr_bits = ^{ifid_instr[31:26], ifid_instr[15:0]};

  assign lu_hazard = idex_dREN && (idex_wsel != 5'd0) &&
                     ((idex_wsel == rs) || (idex_wsel == rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: per-cycle stall/flush resolution for PC and the four
// pipeline registers, sticky halt, and a saturating stall-cycle counter.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [31:0]      ifid_instr,
  input  logic             idex_dREN,
  input  logic [4:0]       idex_wsel,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic             ex_redirect,
  input  logic             memwb_halt,
  output logic             pc_EN,
  output logic             ifid_EN,
  output logic             ifid_flush,
  output logic             idex_EN,
  output logic             idex_flush,
  output logic             exmem_EN,
  output logic             exmem_flush,
  output logic             memwb_EN,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  pctrl_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  pctrl_ctrl_t      ctrl, run_ctrl;
  logic             lu_hazard;
  logic             dmiss;

  load_use_detect u_lu (
    .ifid_instr (ifid_instr),
    .idex_dREN  (idex_dREN),
    .idex_wsel  (idex_wsel),
    .lu_hazard  (lu_hazard)
  );

  assign dmiss = (exmem_dREN | exmem_dWEN) & ~dhit;

  always_comb begin
    run_ctrl = CTRL_GO;
    if (ex_redirect)    run_ctrl = CTRL_REDIR;
    else if (lu_hazard) run_ctrl = CTRL_LU;
    else if (!ihit)     run_ctrl = CTRL_FETCH;
  end

  always_comb begin
    ctrl    = CTRL_GO;
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (dmiss) begin
          ctrl    = CTRL_DSTALL;
          state_d = DWAIT;
        end else begin
          ctrl = run_ctrl;
        end
        if (memwb_halt) state_d = HALT;
      end
      DWAIT: begin
        // The request stays held in EX/MEM, so only dhit is needed to release.
        if (!dhit) begin
          ctrl = CTRL_DSTALL;
        end else begin
          ctrl    = run_ctrl;
          state_d = RUN;
        end
        if (memwb_halt) state_d = HALT;
      end
      HALT: ctrl = CTRL_FROZEN;
      default: begin
        ctrl    = CTRL_FROZEN;
        state_d = RUN;
      end
    endcase
    if (RST) ctrl = CTRL_RESET;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (!ctrl.pc_en && (state_q != HALT) && (cnt_q != '1))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign pc_EN       = ctrl.pc_en;
  assign ifid_EN     = ctrl.ifid_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_EN     = ctrl.idex_en;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_EN    = ctrl.exmem_en;
  assign exmem_flush = ctrl.exmem_flush;
  assign memwb_EN    = ctrl.memwb_en;
  assign memwb_flush = ctrl.memwb_flush;
  assign halted      = (state_q == HALT);
  assign stall_cnt   = cnt_q;

endmodule
